// File: rtl/uart_instruction_sender_if.sv
// rtl/uart_instruction_sender_if.sv - instruction handshake bundle for the sender
//
// Purpose: groups the producer-to-sender instruction handshake.
// Signals:
//   instr_in     [14:0]  instruction word offered by the producer
//   instr_valid          producer offers instr_in
//   instr_ready          sender holding register is empty
// Modports:
//   master  producer side (drives instr_in/instr_valid)
//   slave   sender side (drives instr_ready)

interface uart_instruction_sender_if;
  logic [14:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr_in,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_in,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/uart_instruction_sender.sv
// rtl/uart_instruction_sender.sv - 15-bit instruction frame serializer
//
// Purpose: transmits each accepted instruction as start + 15 data bits
// (LSB first) [+ even parity] + stop, with a one-deep holding register so
// frames can be sent back-to-back.
// Optional feature macro: INSTR_PARITY_EN (inserts an even-parity bit
// between the last data bit and the stop bit).
// Parameters:
//   BAUD_DIVIDER  bit period is BAUD_DIVIDER+1 clocks (>= 1)
//   DATA_BITS     instruction width, fixed at 15
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   instr       instruction handshake (slave modport)
//   tx          serial line, idle high
//   busy        frame in progress or holding register full
//   frame_done  one-clock pulse during the last clock of each stop bit

module uart_instruction_sender #(
  parameter int BAUD_DIVIDER = 434,
  parameter int DATA_BITS    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_instruction_sender_if.slave  instr,
  output logic                      tx,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int                CW       = (BAUD_DIVIDER < 1) ? 1 : $clog2(BAUD_DIVIDER + 1);
  localparam logic [CW-1:0]     BAUD_MAX = CW'(BAUD_DIVIDER);
  localparam logic [3:0]        LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   tx_q, tx_d;
`ifdef INSTR_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic                   bit_end;
  logic                   accept;

  assign bit_end = (baud_q == BAUD_MAX);
  assign accept  = instr.instr_valid && !hold_full_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef INSTR_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
`ifdef INSTR_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
`ifdef INSTR_PARITY_EN
    par_d       = par_q;
`endif

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_START;
          tx_d        = 1'b0;
          baud_d      = '0;
`ifdef INSTR_PARITY_EN
          par_d       = ^hold_q;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q < LAST_IDX) begin
            // shift_q[1] becomes the new LSB after the shift
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 4'd1;
          end else begin
`ifdef INSTR_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end

`ifdef INSTR_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            // Pending word starts immediately: no idle gap between frames
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
            tx_d        = 1'b0;
`ifdef INSTR_PARITY_EN
            par_d       = ^hold_q;
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Acceptance only happens while hold is empty, so it never collides
    // with the hold-drain paths above, which all require hold_full_q.
    if (accept) begin
      hold_d      = instr.instr_in;
      hold_full_d = 1'b1;
    end
  end

  // Outputs: all derived from registered state only
  always_comb begin
    tx                = tx_q;
    instr.instr_ready = !hold_full_q;
    busy              = (state_q != S_IDLE) || hold_full_q;
    frame_done        = (state_q == S_STOP) && bit_end;
  end

endmodule
